mul_seq: RTL

- Iterative shift-and-add multiplier sequencer that sits directly upstream of the 64-bit ripple adder.
- Drives the adder's A/B operands each cycle and captures its sum into an accumulator.
- Produces the low WIDTH bits of an unsigned or two's-complement product, matching ARM MUL semantics (low half only, so it is signedness-agnostic).
- Used by the execute stage for MUL. The adder is instantiated alongside this block and is not inside it.

---
 rtl/mul_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative shift-and-add multiplier sequencer. Feeds an external ripple adder
// one partial product per cycle and keeps the low WIDTH bits of the product.
module mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   product_q, product_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start directly so back-to-back ops have no bubble.
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    count_d  = '0;
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d    = add_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = add_sum;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Adder operands are forced to zero outside BUSY so the adder sits quiet.
    assign busy      = (state_q == ST_BUSY);
    assign done      = (state_q == ST_DONE);
    assign add_a     = busy ? acc_q : '0;
    assign add_b     = (busy && mplier_q[0]) ? mcand_q : '0;
    assign product   = product_q;
    assign state_dbg = state_q;

endmodule
